// File: rtl/lsb_serializer_pkg.sv
// Shared types and constants for the LSB-first parallel-to-serial converter.
// Holds the two-state FSM encoding and the default word width.

package lsb_serializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Bit index counter width; a one-bit floor keeps degenerate widths legal.
    function automatic int count_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/lsb_serializer.sv
// LSB-first parallel-to-serial converter with a ready/valid word input and a
// ready/valid bit output; back-to-back words are emitted without a bubble.

module lsb_serializer
    import lsb_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             ser_ready,
    output logic             ser_valid,
    output logic             ser_data,
    output logic             ser_first,
    output logic             ser_last
);

    localparam int            CW       = count_width(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    count_q, count_d;

    logic in_shift;
    logic at_last;
    logic load_fire;

    assign in_shift  = (state_q == SHIFT);
    assign at_last   = in_shift && (count_q == LAST_IDX);

    // A new word is taken either when empty or exactly as the last bit leaves.
    assign load_ready = !in_shift || (at_last && ser_ready);
    assign load_fire  = load_valid && load_ready;

    assign ser_valid = in_shift;
    assign ser_data  = in_shift && shreg_q[0];
    assign ser_first = in_shift && (count_q == '0);
    assign ser_last  = at_last;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path can infer a latch.
        state_d = state_q;
        shreg_d = shreg_q;
        count_d = count_q;

        if (load_fire) begin
            state_d = SHIFT;
            shreg_d = load_data;
            count_d = '0;
        end else if (in_shift && ser_ready) begin
            if (at_last) begin
                state_d = IDLE;
                shreg_d = '0;
                count_d = '0;
            end else begin
                shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so all of them update from pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_lsb_serializer.sv
// Directed bench for lsb_serializer: a per-cycle vector table for plain and
// back-to-back words, plus hand sequences for stall, reset and WIDTH=4.

module tb_lsb_serializer;

    logic       clk = 1'b0;
    logic       reset;

    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic       ser_ready;
    logic       ser_valid;
    logic       ser_data;
    logic       ser_first;
    logic       ser_last;

    logic       load_valid4;
    logic [3:0] load_data4;
    logic       load_ready4;
    logic       ser_ready4;
    logic       ser_valid4;
    logic       ser_data4;
    logic       ser_first4;
    logic       ser_last4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsb_serializer #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .ser_ready  (ser_ready),
        .ser_valid  (ser_valid),
        .ser_data   (ser_data),
        .ser_first  (ser_first),
        .ser_last   (ser_last)
    );

    lsb_serializer #(.WIDTH(4)) u_dut4 (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid4),
        .load_data  (load_data4),
        .load_ready (load_ready4),
        .ser_ready  (ser_ready4),
        .ser_valid  (ser_valid4),
        .ser_data   (ser_data4),
        .ser_first  (ser_first4),
        .ser_last   (ser_last4)
    );

    typedef struct {
        logic       lv;
        logic [7:0] ld;
        logic       sr;
        logic       e_lr;
        logic       e_sv;
        logic       e_sd;
        logic       e_sf;
        logic       e_sl;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    // One clock cycle on the 8-bit instance: drive, settle, compare, advance.
    task automatic cyc(input logic rst, input logic lv, input logic [7:0] ld, input logic sr,
                       input logic e_lr, input logic e_sv, input logic e_sd,
                       input logic e_sf, input logic e_sl, input string tag);
        reset      = rst;
        load_valid = lv;
        load_data  = ld;
        ser_ready  = sr;
        #1;
        check({tag, ".load_ready"}, load_ready, e_lr);
        check({tag, ".ser_valid"},  ser_valid,  e_sv);
        check({tag, ".ser_data"},   ser_data,   e_sd);
        check({tag, ".ser_first"},  ser_first,  e_sf);
        check({tag, ".ser_last"},   ser_last,   e_sl);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc4(input logic lv, input logic [3:0] ld, input logic sr,
                        input logic e_lr, input logic e_sv, input logic e_sd,
                        input logic e_sf, input logic e_sl, input string tag);
        reset       = 1'b0;
        load_valid4 = lv;
        load_data4  = ld;
        ser_ready4  = sr;
        #1;
        check({tag, ".load_ready"}, load_ready4, e_lr);
        check({tag, ".ser_valid"},  ser_valid4,  e_sv);
        check({tag, ".ser_data"},   ser_data4,   e_sd);
        check({tag, ".ser_first"},  ser_first4,  e_sf);
        check({tag, ".ser_last"},   ser_last4,   e_sl);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] w;
        logic [3:0] w4;

        // Fields: lv, ld, sr | load_ready, ser_valid, ser_data, ser_first, ser_last
        // 8'h05 single word, then IDLE
        vecs.push_back('{1'b1, 8'h05, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        // 8'hA5 then 8'h3C back to back; 3C is offered early and must wait
        vecs.push_back('{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

        reset       = 1'b1;
        load_valid  = 1'b0;
        load_data   = 8'h00;
        ser_ready   = 1'b0;
        load_valid4 = 1'b0;
        load_data4  = 4'h0;
        ser_ready4  = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Post-reset state of both instances
        reset = 1'b0;
        #1;
        check("rst4.load_ready", load_ready4, 1'b1);
        check("rst4.ser_valid",  ser_valid4,  1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rst");

        foreach (vecs[i]) begin
            cyc(1'b0, vecs[i].lv, vecs[i].ld, vecs[i].sr,
                vecs[i].e_lr, vecs[i].e_sv, vecs[i].e_sd, vecs[i].e_sf, vecs[i].e_sl,
                $sformatf("vec%0d", i));
        end

        // 8'hC3 with a 3-cycle stall at bit 3 and a 1-cycle stall on the last bit
        w = 8'hC3;
        cyc(1'b0, 1'b1, w, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "stall.load");
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, w[i], 1'b0, 1'b0,
                               $sformatf("stall.hold%0d", i));
            end
            if (i == 7) begin
                cyc(1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1, w[i], 1'b0, 1'b1,
                    $sformatf("stall.hold%0d", i));
            end
            cyc(1'b0, 1'b0, 8'h00, 1'b1, (i == 7), 1'b1, w[i], (i == 0), (i == 7),
                $sformatf("stall.bit%0d", i));
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "stall.idle");

        // Reset during bit 4 of 8'hFF drops the rest of the word
        cyc(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rstmid.load");
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, (i == 0), 1'b0,
                $sformatf("rstmid.bit%0d", i));
        end
        cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "rstmid.bit4");
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                $sformatf("rstmid.after%0d", i));
        end

        // Reset wins over a load offered in the same cycle
        cyc(1'b1, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rstprio.edge");
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rstprio.after");

        // 8'h11 offered during bit 2 of 8'h00 is refused and never emitted
        cyc(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "ign.load");
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, (i == 2), (i == 2) ? 8'h11 : 8'h00, 1'b1, (i == 7), 1'b1, 1'b0,
                (i == 0), (i == 7), $sformatf("ign.bit%0d", i));
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                $sformatf("ign.idle%0d", i));
        end

        // WIDTH=4 instance: 4'h9 -> 1,0,0,1
        w4 = 4'h9;
        cyc4(1'b1, w4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "w4.load");
        for (int i = 0; i < 4; i++) begin
            cyc4(1'b0, 4'h0, 1'b1, (i == 3), 1'b1, w4[i], (i == 0), (i == 3),
                 $sformatf("w4.bit%0d", i));
        end
        cyc4(1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "w4.idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
